// File: rtl/prog_pkg.sv
// prog_loader shared symbols, FSM states and lane-mask helper.
// Optional checksum stage is enabled by PROG_LOADER_CSUM_EN.
package prog_pkg;

  localparam logic [7:0] START_SYM = 8'h73;
  localparam logic [7:0] END_SYM   = 8'h65;
  localparam logic [7:0] ESC_SYM   = 8'h71;

  typedef enum logic [2:0] {
    ST_PRE,
    ST_HDR,
    ST_DATA,
    ST_ESC,
    ST_DONE,
    ST_CHECK
  } state_t;

  // Low n bits set: strobe for n filled lanes.
  function automatic logic [7:0] lane_mask(input logic [3:0] n);
    logic [15:0] m;
    m = (16'd1 << n) - 16'd1;
    return m[7:0];
  endfunction

endpackage

// File: rtl/prog_word_asm.sv
// Word assembler: lane counter, byte buffer and partial flush.
// Write request and word are combinational; the top registers them.
module prog_word_asm
  import prog_pkg::*;
#(
  parameter int WORD_BYTES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    push,
  input  logic                    flush,
  input  logic [7:0]              byte_in,
  output logic                    wr,
  output logic [8*WORD_BYTES-1:0] wdata,
  output logic [WORD_BYTES-1:0]   wstrb,
  output logic                    pend
);

  localparam logic [3:0] LAST = 4'(WORD_BYTES - 1);

  logic [3:0]              lane_q;
  logic [8*WORD_BYTES-1:0] word_q;
  logic [8*WORD_BYTES-1:0] merged;
  logic [WORD_BYTES-1:0]   fmask;
  logic [8*WORD_BYTES-1:0] fbits;

  assign pend = (lane_q != 4'd0);

  always_comb begin
    merged = word_q;
    fbits  = '0;
    fmask  = WORD_BYTES'(lane_mask(lane_q));
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (lane_q == 4'(i))
        merged[i*8 +: 8] = byte_in;
      fbits[i*8 +: 8] = {8{fmask[i]}};
    end
    wr    = 1'b0;
    wdata = merged;
    wstrb = '1;
    if (flush) begin
      wr    = pend;
      wdata = word_q & fbits;
      wstrb = fmask;
    end else if (push && lane_q == LAST) begin
      wr = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= 4'd0;
      word_q <= '0;
    end else if (clr || flush) begin
      lane_q <= 4'd0;
      word_q <= '0;
    end else if (push) begin
      if (lane_q == LAST) begin
        lane_q <= 4'd0;
        word_q <= '0;
      end else begin
        lane_q <= lane_q + 4'd1;
        word_q <= merged;
      end
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Framed serial program loader writing words to NUM_TARGETS ports.
// Define PROG_LOADER_CSUM_EN for a trailing XOR checksum byte.
module prog_loader
  import prog_pkg::*;
#(
  parameter int WORD_BYTES   = 4,
  parameter int ADDR_W       = 30,
  parameter int NUM_TARGETS  = 2,
  parameter int PREAMBLE_LEN = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   enable,
  input  logic                                   data_tick,
  input  logic [7:0]                             data,
  output logic                                   rst_out,
  output logic [NUM_TARGETS-1:0]                 mem_wen,
  output logic [ADDR_W+$clog2(WORD_BYTES)-1:0]   mem_waddr,
  output logic [8*WORD_BYTES-1:0]                mem_wdata,
  output logic [WORD_BYTES-1:0]                  mem_wstrb,
  output logic                                   done,
  output logic                                   error
);

  localparam int OFF  = $clog2(WORD_BYTES);
  localparam int BA_W = ADDR_W + OFF;
  localparam int AB   = (ADDR_W + 7) / 8;
  localparam int PW   = $clog2(PREAMBLE_LEN + 1);

  localparam logic [PW-1:0] PLEN  = PW'(PREAMBLE_LEN);
  localparam logic [3:0]    HLAST = 4'(AB - 1);
  localparam logic [3:0]    NT    = 4'(NUM_TARGETS);

  state_t              state;
  logic [PW-1:0]       pcnt;
  logic [3:0]          hcnt;
  logic [2:0]          tgt;
  logic [ADDR_W-1:0]   waddr;
  logic [ADDR_W-1:0]   hdr_addr;
`ifdef PROG_LOADER_CSUM_EN
  logic [7:0]          csum;
`endif

  logic tick;
  logic is_start;
  logic is_end;
  logic is_esc;
  logic push;
  logic flush;
  logic clr;

  logic                    asm_wr;
  logic [8*WORD_BYTES-1:0] asm_wdata;
  logic [WORD_BYTES-1:0]   asm_wstrb;
  logic                    asm_pend;

  assign tick     = data_tick & enable;
  assign is_start = (data == START_SYM);
  assign is_end   = (data == END_SYM);
  assign is_esc   = (data == ESC_SYM);

  assign push = tick & ((state == ST_DATA & ~is_start & ~is_end & ~is_esc)
              | state == ST_ESC);
  assign flush = tick & (state == ST_DATA) & is_end;
  assign clr   = ~enable | (state == ST_PRE) | (state == ST_HDR);

  // Little-endian header byte merged into its lane; excess bits drop off.
  assign hdr_addr = (waddr & ~(ADDR_W'(8'hFF) << {hcnt, 3'b000}))
                  | (ADDR_W'(data) << {hcnt, 3'b000});

  prog_word_asm #(
    .WORD_BYTES(WORD_BYTES)
  ) u_asm (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr),
    .push   (push),
    .flush  (flush),
    .byte_in(data),
    .wr     (asm_wr),
    .wdata  (asm_wdata),
    .wstrb  (asm_wstrb),
    .pend   (asm_pend)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_PRE;
      pcnt      <= '0;
      hcnt      <= 4'd0;
      tgt       <= 3'd0;
      waddr     <= '0;
      rst_out   <= 1'b0;
      mem_wen   <= '0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      done      <= 1'b0;
      error     <= 1'b0;
`ifdef PROG_LOADER_CSUM_EN
      csum      <= 8'd0;
`endif
    end else begin
      mem_wen <= '0;
      done    <= 1'b0;
      if (!enable) begin
        state   <= ST_PRE;
        pcnt    <= '0;
        hcnt    <= 4'd0;
        rst_out <= 1'b0;
      end else begin
        if (asm_wr) begin
          mem_wen   <= NUM_TARGETS'(1) << tgt;
          mem_waddr <= BA_W'(waddr) << OFF;
          mem_wdata <= asm_wdata;
          mem_wstrb <= asm_wstrb;
          waddr     <= waddr + 1'b1;
        end
        case (state)
          ST_PRE: if (tick) begin
            if (is_start) begin
              if (pcnt != PLEN)
                pcnt <= pcnt + 1'b1;
            end else if (pcnt == PLEN) begin
              pcnt <= '0;
              if ({1'b0, data[2:0]} >= NT) begin
                error <= 1'b1;
              end else begin
                tgt     <= data[2:0];
                error   <= 1'b0;
                rst_out <= 1'b1;
                hcnt    <= 4'd0;
                state   <= ST_HDR;
              end
            end else begin
              pcnt <= '0;
            end
          end
          ST_HDR: if (tick) begin
            waddr <= hdr_addr;
            hcnt  <= hcnt + 4'd1;
            if (hcnt == HLAST) begin
              state <= ST_DATA;
`ifdef PROG_LOADER_CSUM_EN
              csum  <= 8'd0;
`endif
            end
          end
          ST_DATA: if (tick) begin
            unique case (1'b1)
              is_esc: state <= ST_ESC;
              is_end: begin
`ifdef PROG_LOADER_CSUM_EN
                state <= ST_CHECK;
`else
                if (asm_pend) begin
                  state <= ST_DONE;
                end else begin
                  done    <= 1'b1;
                  rst_out <= 1'b0;
                  state   <= ST_PRE;
                end
`endif
              end
              is_start: begin
                error   <= 1'b1;
                rst_out <= 1'b0;
                pcnt    <= PW'(1);
                state   <= ST_PRE;
              end
              default: begin
`ifdef PROG_LOADER_CSUM_EN
                csum <= csum ^ data;
`endif
              end
            endcase
          end
          ST_ESC: if (tick) begin
`ifdef PROG_LOADER_CSUM_EN
            csum  <= csum ^ data;
`endif
            state <= ST_DATA;
          end
          ST_DONE: begin
            done    <= 1'b1;
            rst_out <= 1'b0;
            state   <= ST_PRE;
          end
`ifdef PROG_LOADER_CSUM_EN
          ST_CHECK: if (tick) begin
            if (data == csum)
              done  <= 1'b1;
            else
              error <= 1'b1;
            rst_out <= 1'b0;
            pcnt    <= '0;
            state   <= ST_PRE;
          end
`endif
          default: state <= ST_PRE;
        endcase
      end
    end
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Parametrised serial-to-memory program loader; the next generation of the single-target byte loader. It consumes a byte stream from the UART receiver, frames it with a start preamble, a header, escaped payload and an end symbol, and writes assembled words to one of NUM_TARGETS write-only memory ports. It holds the core in reset while a frame is active, flushes a trailing partial word with byte strobes, and reports completion and errors.

## Interface
- WORD_BYTES, 4: bytes per memory word (power of two, 1..8)
- ADDR_W, 30: word-address width; byte address is {word_addr, log2(WORD_BYTES) zeros}
- NUM_TARGETS, 2: number of memory write ports (1..8)
- PREAMBLE_LEN, 4: consecutive START_SYM bytes required to arm
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  loader enable; low aborts synchronously, no error flagged
- data_tick  in  1  one-cycle strobe, data valid
- data  in  8  received byte
- rst_out  out  1  core reset request, high from header acceptance until frame completes or aborts
- mem_wen  out  NUM_TARGETS  one-hot write strobe, single cycle
- mem_waddr  out  ADDR_W+log2(WORD_BYTES)  byte address, shared by all targets
- mem_wdata  out  8*WORD_BYTES  word data, first received byte in bits [7:0]
- mem_wstrb  out  WORD_BYTES  byte enables; all ones except on final partial flush
- done  out  1  one-cycle pulse on successful frame completion
- error  out  1  sticky; cleared when the next header is accepted or on reset

## Operation
- Symbols: START_SYM "s", END_SYM "e", ESC_SYM "q"; byte after ESC_SYM is literal payload.
- PREAMBLE: count START_SYM ticks, saturating at PREAMBLE_LEN; a non-START byte with count==PREAMBLE_LEN is the target byte → HDR_ADDR; otherwise count clears.
- Target byte bits [2:0] ≥ NUM_TARGETS → error=1, back to PREAMBLE, no reset request.
- HDR_ADDR: ceil(ADDR_W/8) raw bytes, little-endian, form base word address; excess high bits ignored → DATA.
- DATA: payload byte shifts into word buffer (byte lane = lane counter), lane counter increments; on lane WORD_BYTES-1 issue write. ESC_SYM → DATA_ESC. END_SYM → FLUSH. START_SYM → abort: error=1, rst_out drops, PREAMBLE with count=1.
- DATA_ESC: any byte is payload, → DATA.
- FLUSH: lane counter non-zero → one write with mem_wstrb = lanes filled, unfilled lanes zero; then → CHECK (macro) or DONE.
- DONE: pulse done, rst_out low, → PREAMBLE with count 0.
- Word address increments after every write, wraps modulo 2^ADDR_W without error.
- enable low or rst_n low: state PREAMBLE, counters 0; a write already scheduled for the next cycle is suppressed.

## Timing
- Reset values: rst_out 0, mem_wen 0, mem_waddr 0, mem_wdata 0, mem_wstrb 0, done 0, error 0.
- mem_wen asserts the cycle after the tick completing a word; address, data, strobe are stable that cycle.
- rst_out rises the cycle after the target-byte tick; falls the same cycle done pulses.
- Flush write occurs the cycle after the END_SYM tick; done follows one cycle after the last write (or the tick, if no flush).
- data_tick assumed ≥2 cycles apart; data_tick with enable low ignored.

## Configuration
- PROG_LOADER_CSUM_EN defined: after END_SYM (and flush), next raw byte is checksum = XOR of all unescaped payload bytes; match → done; mismatch → error=1, no done, rst_out still drops. States CHECK added.
- Undefined: END_SYM completes the frame directly; no checksum logic.

## Structure
- Shared package prog_pkg: symbol constants, state enum, lane-mask helper function.
- One sub-module prog_word_asm: lane counter, word buffer, strobe mask, flush; FSM in top.

## Test plan
- WORD_BYTES=4: "ssss",0x00, addr 0x10, bytes 01..08,"e" → two writes target 0 at 0x40 = 0x04030201, 0x44 = 0x08070605; done once.
- Escapes: payload "q","s","q","e","q","q",0x11 "e" → write 0x11716573, strobe 4'b1111, no abort.
- Partial: 5 payload bytes then "e" → second write strobe 4'b0001, data 0x000000xx, rst_out drops after.
- Bad target 0x05 with NUM_TARGETS=2 → error=1, no writes, rst_out never rises.
- Abort: "s" mid-payload → error=1, rst_out falls; three more "s" plus header restart succeeds and clears error.
- CSUM_EN: correct XOR → done; wrong byte → error=1, no done; address 0x3FFFFFFF write then wraps to 0.
